// File: rtl/us_resp_pkg.sv
// Shared types and constants for the ultrasonic echo responder.
// Build option: US_RESP_OUT_OF_RANGE_EN selects timeout echoes for out-of-range distances.
package us_resp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrigHigh,
    StBurst,
    StEcho,
    StHoldoff
  } us_state_e;

  localparam int unsigned TRIG_MIN_US    = 10;
  localparam int unsigned ECHO_US_PER_CM = 58;
  localparam int unsigned MAX_CM         = 400;
  localparam int unsigned TIMEOUT_US     = 38000;

  // Clamp a raw distance into the 1..MAX_CM range the echo counter accepts.
  function automatic logic [8:0] clamp_cm(input logic [9:0] cm);
    if (cm == 10'd0) return 9'd1;
    if (cm > 10'(MAX_CM)) return 9'(MAX_CM);
    return cm[8:0];
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-clock tick every Div clocks, restarted by a synchronous clear.
module us_tick_gen #(
  parameter int unsigned Div = 50
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/us_echo_responder.sv
// Ultrasonic ranging sensor emulator: trigger in, echo pulse of 58 us/cm out.
// Build option: US_RESP_OUT_OF_RANGE_EN gives a TIMEOUT_US echo for distance 0 or > MAX_CM.
module us_echo_responder
  import us_resp_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BURST_US    = 200,
  parameter int unsigned HOLDOFF_US  = 10000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       trig,
  input  logic [9:0] dist_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  localparam int unsigned US_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned UsW    = 20;

  localparam logic [UsW-1:0] TrigMin   = UsW'(TRIG_MIN_US);
  localparam logic [UsW-1:0] TrigSat   = UsW'(15);
  localparam logic [UsW-1:0] BurstLast = UsW'(BURST_US - 1);
  localparam logic [UsW-1:0] HoldLast  = UsW'(HOLDOFF_US - 1);
  localparam logic [5:0]     SubLast   = 6'(ECHO_US_PER_CM - 1);

  logic sync0_q, trig_s_q, trig_prev_q, vld_q, armed_q;
  logic trig_rise, trig_fall, trig_long;
  logic tick, adv;
  logic burst_done, echo_done, hold_done;

  us_state_e      state_q;
  logic [UsW-1:0] us_cnt_q;
  logic [8:0]     cm_q;
  logic [5:0]     sub_q;
  logic           echo_q, busy_q, err_q;
`ifdef US_RESP_OUT_OF_RANGE_EN
  localparam logic [UsW-1:0] TmoLast = UsW'(TIMEOUT_US - 1);
  logic tmo_q;
`endif

  // armed_q blocks a trigger already high at reset release from counting as a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
      vld_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sync0_q     <= trig;
      trig_s_q    <= sync0_q;
      trig_prev_q <= trig_s_q;
      vld_q       <= 1'b1;
      if (vld_q && !sync0_q) armed_q <= 1'b1;
    end
  end

  us_tick_gen #(
    .Div(US_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(reset_n),
    .clr_i (adv),
    .tick_o(tick)
  );

  assign trig_rise  = armed_q & trig_s_q & ~trig_prev_q;
  assign trig_fall  = ~trig_s_q & trig_prev_q;
  // A tick landing on the fall edge still counts toward the minimum width.
  assign trig_long  = (us_cnt_q >= TrigMin) || (tick && (us_cnt_q == TrigMin - 1'b1));
  assign burst_done = tick && (us_cnt_q == BurstLast);
  assign hold_done  = tick && (us_cnt_q == HoldLast);

  always_comb begin
`ifdef US_RESP_OUT_OF_RANGE_EN
    if (tmo_q) echo_done = tick && (us_cnt_q == TmoLast);
    else       echo_done = tick && (sub_q == SubLast) && (cm_q == 9'd1);
`else
    echo_done = tick && (sub_q == SubLast) && (cm_q == 9'd1);
`endif
  end

  always_comb begin
    adv = 1'b0;
    unique case (state_q)
      StIdle:     adv = trig_rise;
      StTrigHigh: adv = trig_fall;
      StBurst:    adv = burst_done;
      StEcho:     adv = echo_done;
      StHoldoff:  adv = hold_done;
      default:    adv = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      us_cnt_q <= '0;
      cm_q     <= '0;
      sub_q    <= '0;
      echo_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef US_RESP_OUT_OF_RANGE_EN
      tmo_q    <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      if (adv) begin
        us_cnt_q <= '0;
      end else if (tick && !(state_q == StTrigHigh && us_cnt_q == TrigSat)) begin
        us_cnt_q <= us_cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (trig_rise) begin
            state_q <= StTrigHigh;
            busy_q  <= 1'b1;
          end
        end
        StTrigHigh: begin
          if (trig_fall) begin
            if (trig_long) begin
              state_q <= StBurst;
`ifdef US_RESP_OUT_OF_RANGE_EN
              if (dist_cm == 10'd0 || dist_cm > 10'(MAX_CM)) begin
                tmo_q <= 1'b1;
                cm_q  <= 9'd1;
              end else begin
                tmo_q <= 1'b0;
                cm_q  <= dist_cm[8:0];
              end
`else
              cm_q <= clamp_cm(dist_cm);
`endif
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        StBurst: begin
          if (burst_done) begin
            state_q <= StEcho;
            echo_q  <= 1'b1;
            sub_q   <= '0;
          end
        end
        StEcho: begin
          if (tick) begin
            if (sub_q == SubLast) begin
              sub_q <= '0;
              cm_q  <= cm_q - 1'b1;
            end else begin
              sub_q <= sub_q + 1'b1;
            end
          end
          if (echo_done) begin
            state_q <= StHoldoff;
            echo_q  <= 1'b0;
          end
        end
        StHoldoff: begin
          if (hold_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign echo     = echo_q;
  assign busy     = busy_q;
  assign trig_err = err_q;

endmodule
